// File: rtl/dual_port_bram_pipelined.sv
// dual_port_bram_pipelined: true dual-port byte-enable RAM with 1..3 cycle read pipeline and post-reset clear sweep
// Ports: clk_i/rst_i clock and sync active-high reset; busy_o high during clear sweep;
//   a_*/b_* en, byte we, addr, wdata in; rdata/valid out; collision_o same-address overlapping-lane write pulse;
//   assert_on_i enables out-of-range address checks.
module dual_port_bram_pipelined #(
  parameter int DataWidth = 32,
  parameter int Depth = 1024,
  parameter int ByteWidth = 8,
  parameter int ReadLatency = 1,
  parameter bit WriteFirst = 1,
  parameter bit ClearOnReset = 1,
  parameter logic [DataWidth-1:0] ClearValue = '0,
  localparam int NumBytes = DataWidth / ByteWidth,
  localparam int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 busy_o,
  input  logic                 a_en_i,
  input  logic [NumBytes-1:0]  a_we_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  output logic [DataWidth-1:0] a_data_o,
  output logic                 a_valid_o,
  input  logic                 b_en_i,
  input  logic [NumBytes-1:0]  b_we_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic [DataWidth-1:0] b_data_o,
  output logic                 b_valid_o,
  output logic                 collision_o,
  input  logic                 assert_on_i
);
  localparam int IdxWidth = $clog2(Depth);
  localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(Depth);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Depth - 1);
  if (DataWidth % ByteWidth != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of ByteWidth");
  end
  if (ReadLatency < 1 || ReadLatency > 3) begin : g_bad_latency
    $error("ReadLatency must be 1..3");
  end
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [IdxWidth-1:0] cnt;
  logic [DataWidth-1:0] mem [Depth];
  logic en [2];
  logic [NumBytes-1:0] we [2];
  logic [AddrWidth-1:0] addr [2];
  logic [DataWidth-1:0] wd [2], old [2], mrg [2], rd [2];
  logic acc [2];
  logic pv [2][ReadLatency];
  logic [DataWidth-1:0] pd [2][ReadLatency];
  logic col_q;
  assign en = '{a_en_i, b_en_i};
  assign we = '{a_we_i, b_we_i};
  assign addr = '{a_addr_i, b_addr_i};
  assign wd = '{a_data_i, b_data_i};
  assign busy_o = state == CLEAR;
  assign a_data_o = pd[0][ReadLatency-1];
  assign a_valid_o = pv[0][ReadLatency-1];
  assign b_data_o = pd[1][ReadLatency-1];
  assign b_valid_o = pv[1][ReadLatency-1];
  // Each port sees its own write merged over the old word (write-first) or the old word alone;
  // the other port's write never reaches this port's read data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p] = en[p] && !busy_o && addr[p] < DepthA;
      old[p] = mem[addr[p][IdxWidth-1:0]];
      mrg[p] = old[p];
      for (int k = 0; k < NumBytes; k++)
        if (we[p][k]) mrg[p][k*ByteWidth +: ByteWidth] = wd[p][k*ByteWidth +: ByteWidth];
      rd[p] = WriteFirst ? mrg[p] : old[p];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ClearOnReset ? CLEAR : READY;
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + IdxWidth'(1);
      if (cnt == LastIdx) state <= READY;
    end
  end
  // Port B is applied first so port A's lanes override it on overlap.
  always_ff @(posedge clk_i) begin
    if (busy_o) mem[cnt] <= ClearValue;
    else
      for (int p = 1; p >= 0; p--)
        for (int k = 0; k < NumBytes; k++)
          if (acc[p] && we[p][k])
            mem[addr[p][IdxWidth-1:0]][k*ByteWidth +: ByteWidth] <= wd[p][k*ByteWidth +: ByteWidth];
  end
  // Data stages only advance with a valid token, so the last stage holds the last delivered word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < ReadLatency; k++) begin
          pv[p][k] <= 1'b0;
          pd[p][k] <= '0;
        end
      col_q <= 1'b0;
      collision_o <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        pv[p][0] <= acc[p];
        if (acc[p]) pd[p][0] <= rd[p];
        for (int k = 1; k < ReadLatency; k++) begin
          pv[p][k] <= pv[p][k-1];
          if (pv[p][k-1]) pd[p][k] <= pd[p][k-1];
        end
      end
      col_q <= acc[0] && acc[1] && addr[0] == addr[1] && |(we[0] & we[1]);
      collision_o <= col_q;
    end
  end
  a_range: assert property (@(posedge clk_i) disable iff (rst_i) !(assert_on_i && a_en_i && a_addr_i >= DepthA))
    else $error("port A address %0d out of range", a_addr_i);
  b_range: assert property (@(posedge clk_i) disable iff (rst_i) !(assert_on_i && b_en_i && b_addr_i >= DepthA))
    else $error("port B address %0d out of range", b_addr_i);
endmodule

// File: tb/tb_dual_port_bram_pipelined.sv
// tb_dual_port_bram_pipelined: scoreboard bench over four RAM instances (latency 1/2/3 write-first, latency 2 read-first)
module tb_dual_port_bram_pipelined;
  localparam logic [31:0] CLR = 32'h5A5A_0000;
  typedef struct { logic [31:0] d; int due; } exp_t;
  logic clk = 0, rst = 0, aon = 1, ae = 0, be = 0;
  logic [3:0] awe = 0, bwe = 0;
  logic [4:0] aad = 0, bad = 0;
  logic [31:0] adi = 0, bdi = 0;
  logic [3:0] busy, col;
  logic [31:0] dat [4][2];
  logic vld [4][2];
  logic [31:0] m [16];
  exp_t q [8][$];
  exp_t e;
  int colq [$];
  int cyc = 0, mcnt = 0, n_chk = 0, n_fail = 0;
  bit started = 0;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dual_port_bram_pipelined #(
      .DataWidth(32), .Depth(16), .ByteWidth(8), .ReadLatency(g == 0 ? 2 : g),
      .WriteFirst(g != 0), .ClearOnReset(1), .ClearValue(CLR)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .busy_o(busy[g]),
      .a_en_i(ae), .a_we_i(awe), .a_addr_i(aad), .a_data_i(adi), .a_data_o(dat[g][0]), .a_valid_o(vld[g][0]),
      .b_en_i(be), .b_we_i(bwe), .b_addr_i(bad), .b_data_i(bdi), .b_data_o(dat[g][1]), .b_valid_o(vld[g][1]),
      .collision_o(col[g]), .assert_on_i(aon)
    );
  end
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) mcnt <= 16;
    else if (mcnt > 0) mcnt <= mcnt - 1;
  end
  function automatic int lat(input int g);
    return g == 0 ? 2 : g;
  endfunction
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
    logic [31:0] r = o;
    for (int k = 0; k < 4; k++) if (w[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (started) begin
    for (int g = 0; g < 4; g++) begin
      check($sformatf("busy_u%0d", g), 32'(busy[g]), 32'(mcnt != 0));
      check($sformatf("collision_u%0d", g), 32'(col[g]), 32'(colq.size() != 0 && colq[0] == cyc));
      for (int p = 0; p < 2; p++) begin
        if (vld[g][p]) begin
          if (q[g*2+p].size() == 0) check($sformatf("unexpected_valid_u%0d_p%0d", g, p), 1, 0);
          else begin
            e = q[g*2+p][0];
            q[g*2+p].delete(0);
            check($sformatf("data_u%0d_p%0d", g, p), dat[g][p], e.d);
            check($sformatf("latency_u%0d_p%0d", g, p), cyc, e.due);
          end
        end
        while (q[g*2+p].size() != 0 && q[g*2+p][0].due < cyc) begin
          q[g*2+p].delete(0);
          check($sformatf("missing_valid_u%0d_p%0d", g, p), 0, 1);
        end
      end
    end
    if (colq.size() != 0 && colq[0] == cyc) colq.delete(0);
  end
  task automatic req(input logic ea, input logic [3:0] wa, input logic [4:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [4:0] ab, input logic [31:0] db);
    logic ka, kb;
    logic [31:0] oa, ob;
    @(negedge clk);
    ae = ea; awe = wa; aad = aa; adi = da;
    be = eb; bwe = wb; bad = ab; bdi = db;
    aon = !(ea && aa >= 16) && !(eb && ab >= 16);
    ka = ea && mcnt == 0 && aa < 16;
    kb = eb && mcnt == 0 && ab < 16;
    oa = m[aa[3:0]];
    ob = m[ab[3:0]];
    for (int g = 0; g < 4; g++) begin
      if (ka) q[g*2].push_back('{g == 0 ? oa : mrg(oa, da, wa), cyc + lat(g)});
      if (kb) q[g*2+1].push_back('{g == 0 ? ob : mrg(ob, db, wb), cyc + lat(g)});
    end
    if (ka && kb && aa == ab && (wa & wb) != 0) colq.push_back(cyc + 2);
    if (kb) m[ab[3:0]] = mrg(m[ab[3:0]], db, wb);
    if (ka) m[aa[3:0]] = mrg(m[aa[3:0]], da, wa);
  endtask
  task automatic idle();
    @(negedge clk);
    ae = 0; be = 0; aon = 1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    ae = 0; be = 0; rst = 1;
    @(negedge clk);
    started = 1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset_busy_u%0d", g), 32'(busy[g]), 1);
      check($sformatf("reset_collision_u%0d", g), 32'(col[g]), 0);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("reset_data_u%0d_p%0d", g, p), dat[g][p], 0);
        check($sformatf("reset_valid_u%0d_p%0d", g, p), 32'(vld[g][p]), 0);
      end
    end
    rst = 0;
    for (int i = 0; i < 16; i++) m[i] = CLR;
  endtask
  task automatic wait_ready();
    while (mcnt != 0) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    req(1, 4'hF, 5'd2, 32'hFFFF_FFFF, 1, 4'h0, 5'd2, 0);
    req(1, 4'hF, 5'd9, 32'h1234_5678, 1, 4'hF, 5'd10, 32'h8765_4321);
    idle();
    wait_ready();
    for (int i = 0; i < 16; i++) req(1, 0, 5'(i), 0, 1, 0, 5'(15 - i), 0);
    req(1, 4'hF, 5'd3, 32'h1122_3344, 0, 0, 0, 0);
    req(1, 4'b0101, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    req(1, 0, 5'd3, 0, 1, 0, 5'd3, 0);
    req(1, 4'hF, 5'd5, 32'h0000_0001, 0, 0, 0, 0);
    req(1, 4'hF, 5'd5, 32'hAAAA_0000, 1, 0, 5'd5, 0);
    req(1, 0, 5'd5, 0, 0, 0, 0, 0);
    req(1, 4'hF, 5'd7, 0, 1, 4'hF, 5'd8, 0);
    req(1, 4'b0001, 5'd7, 32'h0000_00FF, 1, 4'b0011, 5'd7, 32'h0000_FF00);
    req(1, 4'b0001, 5'd8, 32'h0000_0011, 1, 4'b0010, 5'd8, 32'h0000_2200);
    req(1, 4'hF, 5'd9, 32'h1, 1, 4'hF, 5'd10, 32'h2);
    req(1, 0, 5'd7, 0, 1, 0, 5'd8, 0);
    idle();
    for (int i = 0; i < 8; i++) req(0, 0, 0, 0, 1, 0, 5'(i), 0);
    req(0, 0, 0, 0, 1, 0, 5'd16, 0);
    req(1, 4'hF, 5'd16, 32'hBAD0_BAD0, 1, 4'hF, 5'd31, 32'h0BAD_0BAD);
    req(1, 0, 5'd0, 0, 1, 0, 5'd15, 0);
    idle();
    repeat (6) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    req(1, 4'hF, 5'd4, 32'hFFFF_FFFF, 0, 0, 0, 0);
    idle();
    wait_ready();
    for (int i = 0; i < 16; i++) req(1, 0, 5'(i), 0, 1, 0, 5'(i), 0);
    idle();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("drain_q%0d", i), q[i].size(), 0);
    check("drain_collision", colq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
